perf_event_counter_bank: RTL and testbench
==========================================

Name: perf_event_counter_bank

Overview:
Synthesizable, parametrised bank of per-channel event counters plus a free-running cycle counter. It replaces the bench-only instruction and cache hit/request tallies. It sits beside the processor core and caches, with event strobes wired from them (reg write, mem write, I/D cache req/hit). It freezes all counts when the processor halts and exposes them through a registered read port for the bench and for a future memory-mapped status register.

Parameters:
NUM_CH, 6, number of event channels (1..16)
CNT_W, 32, width of each event counter (8..32)
CYC_W, 32, width of cycle counter (8..32)
SEL_W, 5, width of rd_sel; must be >= clog2(NUM_CH+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
enable  in  1  counting enable; leaves IDLE when 1
clear  in  1  synchronous zero of all counters and sticky flags
event  in  NUM_CH  per-channel event strobe, one count per cycle when high
halt  in  1  processor halt strobe
rd_sel  in  SEL_W  read select; 0..NUM_CH-1 = channel, NUM_CH = cycle counter
rd_data  out  32  registered read data, zero-extended
rd_valid  out  1  high the cycle after rd_sel is sampled in a non-reset cycle
frozen  out  1  high in FROZEN state
overflow  out  NUM_CH  sticky per-channel overflow flag
cyc_overflow  out  1  sticky cycle-counter overflow flag

Behaviour:
- Reset (rst=0 at posedge): all counters 0, overflow 0, cyc_overflow 0, rd_data 0, rd_valid 0, state IDLE, frozen 0. Reset mid-run discards all counts.
- FSM states: IDLE, COUNT, FROZEN.
  - IDLE -> COUNT when enable=1. Nothing counts in the transition cycle.
  - COUNT -> IDLE when enable=0. Counts are held, not cleared.
  - COUNT -> FROZEN on halt=1.
  - FROZEN is left only by clear or reset.
- COUNT: each cycle the cycle counter increments by 1, and channel i increments by 1 if event[i]=1.
- The halt cycle is itself counted: events and the cycle asserted together with halt are included. FROZEN holds from the following cycle.
- FROZEN: event, enable and halt are ignored.
- clear has priority over everything except reset. It zeroes all counters, overflow and cyc_overflow, then:
  - next state is COUNT if enable=1, else IDLE;
  - halt asserted in the same cycle is ignored;
  - events in the clear cycle are not counted.
- Wrap (default): a counter at all-ones that increments goes to 0 and sets its sticky overflow bit in the same edge.
- Read port: rd_data <= selected value, zero-extended to 32 bits, with 1-cycle latency. rd_data reflects counter state before the same edge's update. rd_sel > NUM_CH returns 0. Reads are allowed in every state and never disturb counts.
- rd_valid = 1 one cycle after any non-reset cycle.

Optional Feature:
PERF_SAT_EN
- Defined: counters saturate at all-ones instead of wrapping. The overflow bit sets on the first increment attempted at all-ones, and the counter stays all-ones.
- Undefined: wrap behaviour as above.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then rst=1, enable=0, event=all-ones for 10 cycles -> every rd_sel reads 0, frozen=0.
- Basic count: enable=1, event[0] high for 5 cycles, event[2] on alternate cycles over 10 cycles -> ch0=5, ch2=5, cycle counter=10 (excluding the IDLE->COUNT cycle).
- Halt freeze: count 7 cycles with event[1]=1, halt=1 on the 7th -> ch1=7, frozen=1. A further 20 cycles of events leave ch1=7 and cycle=7.
- Clear priority: in FROZEN, assert clear, halt and event[0] together with enable=1 -> all reads 0, state COUNT, frozen=0, ch0=0 the cycle after.
- Overflow (CNT_W=8): drive event[3] for 257 cycles.
  - Wrap build: ch3=1, overflow[3]=1.
  - PERF_SAT_EN build: ch3=255, overflow[3]=1.
- Read port: rd_sel=NUM_CH -> cycle count next cycle; rd_sel=31 -> 0. rd_valid=0 during reset and 1 one cycle after rst releases.

Source files
------------

// File: rtl/perf_event_counter_bank.sv
// Per-channel event counters and a cycle counter with halt freeze and a registered read port.
// Optional macro PERF_SAT_EN: counters saturate at all-ones instead of wrapping.
module perf_event_counter_bank #(
   parameter int NUM_CH = 6,
   parameter int CNT_W  = 32,
   parameter int CYC_W  = 32,
   parameter int SEL_W  = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_clear,
   input  logic [NUM_CH-1:0] i_event,
   input  logic              i_halt,
   input  logic [SEL_W-1:0]  i_rd_sel,
   output logic [31:0]       o_rd_data,
   output logic              o_rd_valid,
   output logic              o_frozen,
   output logic [NUM_CH-1:0] o_overflow,
   output logic              o_cyc_overflow
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_count_en;
   logic              r_frozen;
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic [NUM_CH-1:0] r_ovf;
   logic [CYC_W-1:0]  r_cyc;
   logic              r_cyc_ovf;
   logic [31:0]       w_rd_mux;
   logic [31:0]       r_rd_data;
   logic              r_rd_valid;

   // Next-state decode; clear overrides halt and the frozen hold.
   always_comb begin
      w_next_state = r_state;
      w_count_en   = 1'b0;
      if (i_clear) begin
         w_next_state = i_enable ? ST_COUNT : ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_enable) w_next_state = ST_COUNT;
               else          w_next_state = ST_IDLE;
            end
            ST_COUNT: begin
               w_count_en = 1'b1;
               if (i_halt)         w_next_state = ST_FROZEN;
               else if (!i_enable) w_next_state = ST_IDLE;
               else                w_next_state = ST_COUNT;
            end
            ST_FROZEN: w_next_state = ST_FROZEN;
            default:   w_next_state = ST_IDLE;
         endcase
      end
   end

   // State register and registered frozen flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state  <= ST_IDLE;
         r_frozen <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_frozen <= (w_next_state == ST_FROZEN);
      end
   end

   // Event channel counters with sticky overflow.
   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clear) begin
         for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= {CNT_W{1'b0}};
         r_ovf <= {NUM_CH{1'b0}};
      end else if (w_count_en) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (i_event[k]) begin
               if (&r_cnt[k]) begin
                  r_ovf[k] <= 1'b1;
`ifdef PERF_SAT_EN
                  r_cnt[k] <= r_cnt[k];
`else
                  r_cnt[k] <= {CNT_W{1'b0}};
`endif
               end else begin
                  r_cnt[k] <= r_cnt[k] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Free-running cycle counter, active only in COUNT.
   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clear) begin
         r_cyc     <= {CYC_W{1'b0}};
         r_cyc_ovf <= 1'b0;
      end else if (w_count_en) begin
         if (&r_cyc) begin
            r_cyc_ovf <= 1'b1;
`ifdef PERF_SAT_EN
            r_cyc <= r_cyc;
`else
            r_cyc <= {CYC_W{1'b0}};
`endif
         end else begin
            r_cyc <= r_cyc + CYC_W'(1);
         end
      end
   end

   // One-hot OR mux keeps out-of-range selects at zero without index-width hazards.
   always_comb begin
      w_rd_mux = 32'd0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_rd_mux = w_rd_mux | ({32{i_rd_sel == SEL_W'(k)}} & 32'(r_cnt[k]));
      end
      w_rd_mux = w_rd_mux | ({32{i_rd_sel == SEL_W'(NUM_CH)}} & 32'(r_cyc));
   end

   // Registered read port, sampling pre-update counter values.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_rd_data  <= 32'd0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_data  <= w_rd_mux;
         r_rd_valid <= 1'b1;
      end
   end

   assign o_rd_data      = r_rd_data;
   assign o_rd_valid     = r_rd_valid;
   assign o_frozen       = r_frozen;
   assign o_overflow     = r_ovf;
   assign o_cyc_overflow = r_cyc_ovf;

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Directed bench for perf_event_counter_bank with a reference model and read-data scoreboard.
module tb_perf_event_counter_bank;

   localparam int NUM_CH = 6;
   localparam int CNT_W  = 8;
   localparam int CYC_W  = 8;
   localparam int SEL_W  = 5;
   localparam int CMAX   = 255;

   logic              clk = 1'b0;
   logic              i_rst, i_enable, i_clear, i_halt;
   logic [NUM_CH-1:0] i_event;
   logic [SEL_W-1:0]  i_rd_sel;
   logic [31:0]       o_rd_data;
   logic              o_rd_valid, o_frozen, o_cyc_overflow;
   logic [NUM_CH-1:0] o_overflow;

   int checks   = 0;
   int failures = 0;

   logic [31:0] sb_q[$];

   int          m_state;
   int          m_ch [NUM_CH];
   int          m_cyc;
   logic [NUM_CH-1:0] m_ovf;
   logic        m_cyc_ovf;

   perf_event_counter_bank #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYC_W(CYC_W), .SEL_W(SEL_W)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_clear(i_clear),
      .i_event(i_event), .i_halt(i_halt), .i_rd_sel(i_rd_sel),
      .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_frozen(o_frozen),
      .o_overflow(o_overflow), .o_cyc_overflow(o_cyc_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [SEL_W-1:0] sel);
      if (sel < NUM_CH) return 32'(m_ch[sel]);
      else if (sel == SEL_W'(NUM_CH)) return 32'(m_cyc);
      else return 32'd0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) m_ch[k] = 0;
      m_cyc = 0; m_ovf = '0; m_cyc_ovf = 1'b0;
   endtask

   task automatic model_update(input logic en, input logic clr, input logic hlt,
                               input logic [NUM_CH-1:0] ev);
      if (clr) begin
         model_reset();
         m_state = en ? 1 : 0;
      end else if (m_state == 0) begin
         if (en) m_state = 1;
      end else if (m_state == 1) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ev[k]) begin
               if (m_ch[k] == CMAX) begin
                  m_ovf[k] = 1'b1;
`ifdef PERF_SAT_EN
                  m_ch[k] = CMAX;
`else
                  m_ch[k] = 0;
`endif
               end else m_ch[k]++;
            end
         end
         if (m_cyc == CMAX) begin
            m_cyc_ovf = 1'b1;
`ifdef PERF_SAT_EN
            m_cyc = CMAX;
`else
            m_cyc = 0;
`endif
         end else m_cyc++;
         if (hlt) m_state = 2;
         else if (!en) m_state = 0;
      end
   endtask

   task automatic step(input logic en, input logic clr, input logic hlt,
                       input logic [NUM_CH-1:0] ev, input logic [SEL_W-1:0] sel);
      i_rst = 1'b1; i_enable = en; i_clear = clr; i_halt = hlt;
      i_event = ev; i_rd_sel = sel;
      sb_q.push_back(model_read(sel));
      model_update(en, clr, hlt, ev);
      @(posedge clk); #1;
      if (sb_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else chk($sformatf("rd_data sel=%0d", sel), o_rd_data, sb_q.pop_front());
      chk("rd_valid", 32'(o_rd_valid), 32'd1);
      chk("frozen", 32'(o_frozen), 32'(m_state == 2));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("cyc_overflow", 32'(o_cyc_overflow), 32'(m_cyc_ovf));
   endtask

   task automatic rst_step();
      i_rst = 1'b0; i_enable = 1'b1; i_clear = 1'b0; i_halt = 1'b0;
      i_event = '1; i_rd_sel = SEL_W'(NUM_CH);
      model_reset();
      m_state = 0;
      @(posedge clk); #1;
      chk("rst rd_valid", 32'(o_rd_valid), 32'd0);
      chk("rst rd_data", o_rd_data, 32'd0);
      chk("rst frozen", 32'(o_frozen), 32'd0);
      chk("rst overflow", 32'(o_overflow), 32'd0);
      chk("rst cyc_overflow", 32'(o_cyc_overflow), 32'd0);
   endtask

   initial begin
      i_rst = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_halt = 1'b0;
      i_event = '0; i_rd_sel = '0;
      m_state = 0;
      model_reset();

      // Reset, then idle with all events high: nothing counts.
      rst_step();
      rst_step();
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '1, SEL_W'(i % 8));

      // Basic count: one idle->count cycle, then 10 counting cycles.
      step(1'b1, 1'b0, 1'b0, '1, SEL_W'(0));
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b0, 1'b0, {3'b000, 1'b0, (i % 2 == 0), 1'b0, (i < 5)} , SEL_W'(i % 7));
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(NUM_CH));
      chk("basic cyc", o_rd_data, 32'd10);
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(0));
      chk("basic ch0", o_rd_data, 32'd5);
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(2));
      chk("basic ch2", o_rd_data, 32'd5);

      // Halt freeze: 7 counted cycles, halt on the 7th.
      step(1'b1, 1'b1, 1'b0, '0, SEL_W'(1));
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, (i == 6), 6'b000010, SEL_W'(1));
      chk("halt frozen", 32'(o_frozen), 32'd1);
      for (int i = 0; i < 20; i++)
         step((i % 3 != 0), 1'b0, (i % 2 == 1), '1, (i % 2 == 0) ? SEL_W'(1) : SEL_W'(NUM_CH));
      step(1'b1, 1'b0, 1'b0, '1, SEL_W'(1));
      chk("frozen ch1", o_rd_data, 32'd7);
      step(1'b1, 1'b0, 1'b1, '1, SEL_W'(NUM_CH));
      chk("frozen cyc", o_rd_data, 32'd7);

      // Clear wins over halt and events, and restarts counting.
      step(1'b1, 1'b1, 1'b1, 6'b000001, SEL_W'(1));
      step(1'b1, 1'b0, 1'b0, '0, SEL_W'(0));
      chk("clear ch0", o_rd_data, 32'd0);
      chk("clear unfrozen", 32'(o_frozen), 32'd0);
      step(1'b1, 1'b0, 1'b0, '0, SEL_W'(NUM_CH));
      chk("clear counting cyc", o_rd_data, 32'd1);

      // Overflow on ch3 after 257 events; cycle counter also crosses its limit.
      step(1'b1, 1'b1, 1'b0, '0, SEL_W'(3));
      for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 1'b0, 6'b001000, SEL_W'(3));
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(3));
`ifdef PERF_SAT_EN
      chk("ovf ch3", o_rd_data, 32'd255);
`else
      chk("ovf ch3", o_rd_data, 32'd1);
`endif
      chk("ovf flag3", 32'(o_overflow), 32'h08);
      chk("cyc ovf flag", 32'(o_cyc_overflow), 32'd1);
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(NUM_CH));
`ifdef PERF_SAT_EN
      chk("ovf cyc", o_rd_data, 32'd255);
`else
      chk("ovf cyc", o_rd_data, 32'd2);
`endif
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(31));
      chk("sel31 zero", o_rd_data, 32'd0);

      // Reset mid-run discards counts.
      step(1'b1, 1'b0, 1'b0, '1, SEL_W'(0));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '1, SEL_W'(i));
      rst_step();
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(3));
      chk("post-rst ch3", o_rd_data, 32'd0);
      step(1'b0, 1'b0, 1'b0, '0, SEL_W'(NUM_CH));
      chk("post-rst cyc", o_rd_data, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
